reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
// - 32 x 32-bit general-purpose register file of the single-cycle CPU; the source of both ALU
//   operands (a <- rs_data, b <- rt_data via operand mux) and the sink of the ALU/memory result.
// - Two combinational read ports, one clocked write port, one debug read port for the bench.
// - Register 0 is hardwired to zero; $gp/$sp take programmable reset values.
// PARAMETERS
// - DATA_W   32            register/data width
// - ADDR_W   5             register index width (2**ADDR_W registers)
// - SP_INIT  32'h00003FFC  reset value of register 29 ($sp)
// - GP_INIT  32'h00001800  reset value of register 28 ($gp)
// - BYPASS   1             1: same-cycle write data forwarded to rs/rt read ports; 0: no forwarding
// PORTS
// - clk       in   1       clock, all state updates on rising edge
// - rst       in   1       asynchronous, active-high reset
// - rs_addr   in   ADDR_W  read port A index (instr[25:21])
// - rt_addr   in   ADDR_W  read port B index (instr[20:16])
// - rs_data   out  DATA_W  read port A data -> ALU input a
// - rt_data   out  DATA_W  read port B data -> ALU input b / store data
// - wr_en     in   1       write enable (RegWrite)
// - wr_addr   in   ADDR_W  write index (rd or rt, selected upstream)
// - wr_data   in   DATA_W  write data (ALU result or load data)
// - dbg_addr  in   ADDR_W  debug read index
// - dbg_data  out  DATA_W  debug read data, never forwarded
// BEHAVIOUR
// - Reset (async, asserted): all registers 0 except r28=GP_INIT, r29=SP_INIT; takes effect
//   immediately, independent of clk. Read outputs then reflect reset contents (0 unless index 28/29).
// - Reset wins over a write in the same edge; no write is performed while rst is high.
// - Write: on rising clk edge with rst=0, wr_en=1, wr_addr!=0 -> reg[wr_addr] <= wr_data. Latency
//   1 cycle to the array. Writes to index 0 silently dropped; reg[0] reads 0 always.
// - Read: purely combinational from array; no clock latency.
// - Bypass (BYPASS=1): if wr_en=1, rst=0, wr_addr!=0 and wr_addr==rs_addr, rs_data=wr_data in the
//   same cycle; same rule for rt. Both ports may forward simultaneously (rs_addr==rt_addr==wr_addr).
// - Bypass never applies to index 0, to dbg_data, or while rst=1.
// - BYPASS=0: reads return pre-edge array contents; new value visible the cycle after the write.
// - No X propagation: unwritten registers hold reset value; wr_data is stored bit-exact (no extension).
// - wr_en=1 with wr_addr=0 is legal and has no effect; no error flag.
// STRUCTURE
// - Shared package (cpu_pkg): DATA_W, ADDR_W, REG_ZERO=0, REG_GP=28, REG_SP=29, REG_RA=31,
//   SP_INIT/GP_INIT defaults; also used by control and ALU-operand mux.
// - One sub-module: reg_file_rdport (array read mux + bypass compare), instantiated for rs and rt;
//   debug port is a plain array index in reg_file.
// - Storage: reg array [1:2**ADDR_W-1]; index 0 decoded as constant zero.
// TESTING
// - Assert rst mid-cycle (no clk edge) after writes -> dbg_data for r5=0, r28=32'h1800, r29=32'h3FFC at once.
// - wr_en=1, wr_addr=8, wr_data=32'hDEADBEEF, edge -> next cycle rs_addr=8 gives 32'hDEADBEEF.
// - wr_en=1, wr_addr=0, wr_data=32'hFFFFFFFF, edge -> rs_addr=0, rt_addr=0, dbg_addr=0 all read 0.
// - BYPASS=1: same cycle wr_en=1, wr_addr=9, wr_data=32'h12345678, rs_addr=rt_addr=9 -> both 32'h12345678
//   before the edge; dbg_addr=9 still shows old value 0 until the edge.
// - rst=1 on same edge as wr_en=1, wr_addr=29, wr_data=32'h0 -> r29 stays 32'h3FFC; no bypass during rst.
// - Random 1000-cycle write/read mix vs. reference model array (both BYPASS values) -> zero mismatches.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, architectural register indices, reset defaults.
package cpu_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;
  localparam int REG_GP   = 28;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;
  localparam logic [DATA_W-1:0] SP_INIT_DEF = 32'h0000_3FFC;
  localparam logic [DATA_W-1:0] GP_INIT_DEF = 32'h0000_1800;
endpackage

// File: rtl/reg_file_rdport.sv
// One combinational register-file read port: array select plus optional same-cycle write forwarding.
module reg_file_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  output logic [DATA_W-1:0]                rd_data
);
  logic hit;

  // r0 is never forwarded, so a dropped write to r0 cannot leak onto a read port
  assign hit     = BYPASS && !rst && wr_en && (wr_addr != '0) && (wr_addr == rd_addr);
  assign rd_data = hit ? wr_data : regs[rd_addr];
endmodule

// File: rtl/reg_file.sv
// 32x32 CPU register file: two forwarding read ports (rs, rt), one write port, one raw debug port.
module reg_file #(
  parameter int                 DATA_W  = cpu_pkg::DATA_W,
  parameter int                 ADDR_W  = cpu_pkg::ADDR_W,
  parameter logic [DATA_W-1:0]  SP_INIT = cpu_pkg::SP_INIT_DEF,
  parameter logic [DATA_W-1:0]  GP_INIT = cpu_pkg::GP_INIT_DEF,
  parameter bit                 BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  import cpu_pkg::*;

  localparam int NREG  = 2**ADDR_W;
  localparam int NPORT = 2;

  logic [DATA_W-1:0]                mem [1:NREG-1];
  logic [NREG-1:0][DATA_W-1:0]      regs;
  logic [NPORT-1:0][ADDR_W-1:0]     rd_addr;
  logic [NPORT-1:0][DATA_W-1:0]     rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++)
        mem[i] <= (i == REG_GP) ? GP_INIT : (i == REG_SP) ? SP_INIT : '0;
    end else if (wr_en && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // flat view with r0 decoded as constant zero
  always_comb begin
    regs[0] = '0;
    for (int i = 1; i < NREG; i++) regs[i] = mem[i];
  end

  assign rd_addr[0] = rs_addr;
  assign rd_addr[1] = rt_addr;

  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    reg_file_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rdport (
      .regs    (regs),
      .rd_addr (rd_addr[p]),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[p])
    );
  end

  assign rs_data  = rd_data[0];
  assign rt_data  = rd_data[1];
  assign dbg_data = regs[dbg_addr];
endmodule

// File: tb/tb_reg_file.sv
// Directed and randomized checks of reg_file with forwarding on (u_byp) and off (u_nob).
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs_addr = '0, rt_addr = '0, wr_addr = '0, dbg_addr = '0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] b_rs, b_rt, b_dbg, n_rs, n_rt, n_dbg;
  logic [31:0] mdl [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  reg_file #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(b_rs), .rt_data(b_rt),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(b_dbg)
  );

  reg_file #(.BYPASS(1'b0)) u_nob (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(n_rs), .rt_data(n_rt),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(n_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    mdl[28] = 32'h0000_1800;
    mdl[29] = 32'h0000_3FFC;
  endtask

  // one clock edge; the model follows the same write rule, then settle past the edge
  task automatic step();
    @(posedge clk);
    if (rst) mdl_reset();
    else if (wr_en && wr_addr != 5'd0) mdl[wr_addr] = wr_data;
    #1;
  endtask

  initial begin
    mdl_reset();
    #1 rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // reset contents
    dbg_addr = 5'd0;  rs_addr = 5'd28; rt_addr = 5'd29; #1;
    chk("rst_dbg_r0", b_dbg, 32'h0);
    chk("rst_rs_r28", b_rs, 32'h1800);
    chk("rst_rt_r29", n_rt, 32'h3FFC);
    dbg_addr = 5'd5; #1;
    chk("rst_dbg_r5", b_dbg, 32'h0);

    // plain write then read next cycle; no-forward copy still shows old value pre-edge
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEADBEEF; rs_addr = 5'd8; #1;
    chk("nob_pre_edge_r8", n_rs, 32'h0);
    step();
    wr_en = 1'b0; #1;
    chk("byp_rs_r8", b_rs, 32'hDEADBEEF);
    chk("nob_rs_r8", n_rs, 32'hDEADBEEF);

    // write to r0 dropped, never forwarded
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rs_addr = 5'd0; rt_addr = 5'd0; dbg_addr = 5'd0; #1;
    chk("byp_rs_r0_fwd", b_rs, 32'h0);
    step();
    wr_en = 1'b0; #1;
    chk("byp_rs_r0", b_rs, 32'h0);
    chk("byp_rt_r0", b_rt, 32'h0);
    chk("byp_dbg_r0", b_dbg, 32'h0);
    chk("nob_rs_r0", n_rs, 32'h0);

    // same-cycle forwarding on both ports, debug unforwarded
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h12345678;
    rs_addr = 5'd9; rt_addr = 5'd9; dbg_addr = 5'd9; #1;
    chk("byp_rs_fwd_r9", b_rs, 32'h12345678);
    chk("byp_rt_fwd_r9", b_rt, 32'h12345678);
    chk("byp_dbg_r9_old", b_dbg, 32'h0);
    chk("nob_rs_r9_old", n_rs, 32'h0);
    step();
    wr_en = 1'b0; #1;
    chk("byp_dbg_r9_new", b_dbg, 32'h12345678);
    chk("nob_rt_r9_new", n_rt, 32'h12345678);

    // async reset mid-cycle after writes
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h5555AAAA; step();
    wr_en = 1'b0; dbg_addr = 5'd5; #1;
    chk("pre_rst_r5", b_dbg, 32'h5555AAAA);
    @(negedge clk);
    rst = 1'b1; mdl_reset(); #1;
    chk("async_rst_r5", b_dbg, 32'h0);
    dbg_addr = 5'd28; #1;
    chk("async_rst_r28", b_dbg, 32'h1800);
    dbg_addr = 5'd29; #1;
    chk("async_rst_r29", n_dbg, 32'h3FFC);
    chk("async_rst_r9", u_byp.regs[9], 32'h0);

    // reset beats a write on the same edge, and blocks forwarding
    wr_en = 1'b1; wr_addr = 5'd29; wr_data = 32'h0; rs_addr = 5'd29; #1;
    chk("rst_no_fwd_rs", b_rs, 32'h3FFC);
    step();
    rst = 1'b0; wr_en = 1'b0; #1;
    chk("rst_wins_r29", b_dbg, 32'h3FFC);
    step();
    chk("rst_wins_r29_after", n_dbg, 32'h3FFC);

    // randomized write/read mix against the model
    for (int c = 0; c < 1000; c++) begin
      logic        fwd_rs, fwd_rt;
      wr_en    = ($urandom_range(0, 3) != 0);
      wr_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      rs_addr  = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rt_addr  = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      dbg_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      #1;
      fwd_rs = wr_en && wr_addr != 5'd0 && wr_addr == rs_addr;
      fwd_rt = wr_en && wr_addr != 5'd0 && wr_addr == rt_addr;
      chk("rnd_byp_rs", b_rs, fwd_rs ? wr_data : mdl[rs_addr]);
      chk("rnd_byp_rt", b_rt, fwd_rt ? wr_data : mdl[rt_addr]);
      chk("rnd_byp_dbg", b_dbg, mdl[dbg_addr]);
      chk("rnd_nob_rs", n_rs, mdl[rs_addr]);
      chk("rnd_nob_rt", n_rt, mdl[rt_addr]);
      chk("rnd_nob_dbg", n_dbg, mdl[dbg_addr]);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
